// File: rtl/memory_ctrl_pkg.sv
// Shared types and default sizing for the cache miss sequencer.
package memory_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } mc_state_t;

  localparam int unsigned MEM_LATENCY_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/memory_controller_if.sv
// Handshake between the CPU/cache datapath and the miss sequencer.
interface memory_controller_if;

  logic cpu_req;
  logic hit;
  logic dirty_bit;
  logic cpu_ready;
  logic cache_we;
  logic mem_in_select;
  logic mem_we;
  logic mem_re;

  modport master (
    output cpu_req, hit, dirty_bit,
    input  cpu_ready, cache_we, mem_in_select, mem_we, mem_re
  );

  modport slave (
    input  cpu_req, hit, dirty_bit,
    output cpu_ready, cache_we, mem_in_select, mem_we, mem_re
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing one main-memory line transfer; done marks the last cycle.
module mem_wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/memory_controller.sv
// Cache miss sequencer: write-back, refill, replay, plus saturating hit/miss/write-back statistics.
module memory_controller
  import memory_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  memory_controller_if.slave   bus,
  input  logic                 clear_stats,
  output logic                 busy,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     wb_count
);

  localparam int unsigned     WAIT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [WAIT_W-1:0] LAST_LOAD = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [WAIT_W-1:0] PENULT    = WAIT_W'(1);
  localparam logic            ONE_CYCLE = 1'(MEM_LATENCY == 1);

  mc_state_t         state;
  logic              refilled;
  logic              cache_we_q;
  logic              sel_q;
  logic              we_q;
  logic              re_q;
  logic              miss_c;
  logic              ready_c;
  logic              wait_load;
  logic              wait_done;
  logic [WAIT_W-1:0] wait_cnt;

  assign miss_c    = (state == IDLE) && bus.cpu_req && !bus.hit;
  assign ready_c   = rst_b && (state == IDLE) && bus.cpu_req && bus.hit;
  assign wait_load = miss_c || ((state == WRITEBACK) && wait_done);

  mem_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (wait_load),
    .load_val (LAST_LOAD),
    .cnt      (wait_cnt),
    .done     (wait_done)
  );

  // Sequencer; memory strobes are registered one cycle ahead so they track state exactly.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      refilled   <= 1'b0;
      cache_we_q <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.cpu_req || bus.hit) begin
            refilled <= 1'b0;
          end
          if (miss_c) begin
            busy <= 1'b1;
            if (bus.dirty_bit) begin
              state <= WRITEBACK;
              sel_q <= 1'b1;
              we_q  <= 1'b1;
            end else begin
              state      <= REFILL;
              re_q       <= 1'b1;
              cache_we_q <= ONE_CYCLE;
            end
          end
        end
        WRITEBACK: begin
          if (wait_done) begin
            state      <= REFILL;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b1;
            cache_we_q <= ONE_CYCLE;
          end
        end
        REFILL: begin
          if (wait_done) begin
            state      <= IDLE;
            re_q       <= 1'b0;
            cache_we_q <= 1'b0;
            busy       <= 1'b0;
            refilled   <= 1'b1;
          end else begin
            cache_we_q <= (wait_cnt == PENULT);
          end
        end
        default: begin
          state      <= IDLE;
          sel_q      <= 1'b0;
          we_q       <= 1'b0;
          re_q       <= 1'b0;
          cache_we_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ready     = ready_c;
  assign bus.cache_we      = cache_we_q;
  assign bus.mem_in_select = sel_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_re        = re_q;

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (clear_stats) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (ready_c && !refilled && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_c && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_W'(1);
      end
      if (miss_c && bus.dirty_bit && (wb_count != '1)) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: cycle tables for hit/clean/dirty miss plus reset, withdrawal, saturation and single-cycle latency.
module tb_memory_controller;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       clr = 1'b0;
  logic       busy;
  logic [3:0] hc, mc, wc;

  logic        clr1 = 1'b0;
  logic        busy1;
  logic [15:0] hc1, mc1, wc1;

  int n_pass = 0;
  int n_total = 0;

  memory_controller_if bus ();
  memory_controller_if bus1 ();

  memory_controller #(.MEM_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus), .clear_stats(clr),
    .busy(busy), .hit_count(hc), .miss_count(mc), .wb_count(wc)
  );

  memory_controller #(.MEM_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_b(rst_b), .bus(bus1), .clear_stats(clr1),
    .busy(busy1), .hit_count(hc1), .miss_count(mc1), .wb_count(wc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req, hit, dirty, clr;
    logic rdy, cwe, sel, we, re, bsy;
    int   hcnt, mcnt, wcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic req, logic hit, logic dirty,
                              logic rdy, logic cwe, logic sel, logic we, logic re, logic bsy,
                              int hcnt, int mcnt, int wcnt);
    vec_t v;
    v.req = req; v.hit = hit; v.dirty = dirty; v.clr = 1'b0;
    v.rdy = rdy; v.cwe = cwe; v.sel = sel; v.we = we; v.re = re; v.bsy = bsy;
    v.hcnt = hcnt; v.mcnt = mcnt; v.wcnt = wcnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic req, input logic hit, input logic dirty);
    bus.cpu_req = req; bus.hit = hit; bus.dirty_bit = dirty;
  endtask

  task automatic drive1(input logic req, input logic hit, input logic dirty);
    bus1.cpu_req = req; bus1.hit = hit; bus1.dirty_bit = dirty;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic cwe, input logic sel,
                          input logic we, input logic re, input logic bsy);
    chk({tag, ".cpu_ready"}, int'(bus.cpu_ready), int'(rdy));
    chk({tag, ".cache_we"}, int'(bus.cache_we), int'(cwe));
    chk({tag, ".mem_in_select"}, int'(bus.mem_in_select), int'(sel));
    chk({tag, ".mem_we"}, int'(bus.mem_we), int'(we));
    chk({tag, ".mem_re"}, int'(bus.mem_re), int'(re));
    chk({tag, ".busy"}, int'(busy), int'(bsy));
  endtask

  task automatic chk_outs1(input string tag, input logic rdy, input logic cwe, input logic sel,
                           input logic we, input logic re, input logic bsy);
    chk({tag, ".cpu_ready"}, int'(bus1.cpu_ready), int'(rdy));
    chk({tag, ".cache_we"}, int'(bus1.cache_we), int'(cwe));
    chk({tag, ".mem_in_select"}, int'(bus1.mem_in_select), int'(sel));
    chk({tag, ".mem_we"}, int'(bus1.mem_we), int'(we));
    chk({tag, ".mem_re"}, int'(bus1.mem_re), int'(re));
    chk({tag, ".busy"}, int'(busy1), int'(bsy));
  endtask

  // One cycle: drive just after the rising edge, check at the falling edge.
  task automatic cyc(input logic req, input logic hit, input logic dirty);
    @(posedge clk); #1;
    drive(req, hit, dirty);
    @(negedge clk);
  endtask

  task automatic cyc1(input logic req, input logic hit, input logic dirty);
    @(posedge clk); #1;
    drive1(req, hit, dirty);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);

    // Hit, idle, clean miss with replay, idle, dirty miss with replay, idle.
    tbl.push_back(mk(1,1,0, 1,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 1,0,0));
    tbl.push_back(mk(1,0,0, 0,0,0,0,0,0, 1,0,0));
    tbl.push_back(mk(1,0,1, 0,0,0,0,1,1, 1,1,0));
    tbl.push_back(mk(1,1,0, 0,0,0,0,1,1, 1,1,0));
    tbl.push_back(mk(1,0,0, 0,0,0,0,1,1, 1,1,0));
    tbl.push_back(mk(1,0,0, 0,1,0,0,1,1, 1,1,0));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,1, 0,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,1, 1,2,1));
    tbl.push_back(mk(1,1,0, 0,0,1,1,0,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,0,0,0,1,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,0,0,0,1,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,0,0,0,1,1, 1,2,1));
    tbl.push_back(mk(1,0,0, 0,1,0,0,1,1, 1,2,1));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0,0, 1,2,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 1,2,1));

    // Reset state, with a request that would otherwise be a hit.
    drive(1'b1, 1'b1, 1'b0);
    #2;
    chk_outs("reset", 0,0,0,0,0,0);
    chk("reset.hit_count", int'(hc), 0);
    @(negedge clk); #2;
    drive(1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      clr = tbl[i].clr;
      cyc(tbl[i].req, tbl[i].hit, tbl[i].dirty);
      chk_outs(tag, tbl[i].rdy, tbl[i].cwe, tbl[i].sel, tbl[i].we, tbl[i].re, tbl[i].bsy);
      chk({tag, ".hit_count"}, int'(hc), tbl[i].hcnt);
      chk({tag, ".miss_count"}, int'(mc), tbl[i].mcnt);
      chk({tag, ".wb_count"}, int'(wc), tbl[i].wcnt);
    end

    // Request withdrawn during a clean miss: refill still completes, no ready, next hit counts.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_outs("wd.c4", 0,1,0,0,1,1);
    cyc(0, 1, 0);
    chk_outs("wd.c5", 0,0,0,0,0,0);
    cyc(1, 1, 0);
    chk_outs("wd.newhit", 1,0,0,0,0,0);
    cyc(0, 0, 0);
    chk("wd.hit_count", int'(hc), 2);
    chk("wd.miss_count", int'(mc), 3);

    // Reset asserted in cycle 2 of a write-back.
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk_outs("rwb.c1", 0,0,1,1,0,1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0);
    rst_b = 1'b0;
    #1;
    chk_outs("rwb.inrst", 0,0,0,0,0,0);
    chk("rwb.hit_count", int'(hc), 0);
    chk("rwb.miss_count", int'(mc), 0);
    chk("rwb.wb_count", int'(wc), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    cyc(0, 0, 0);
    chk_outs("rwb.after", 0,0,0,0,0,0);

    // Saturation at CNT_W=4, then clear with a simultaneous hit.
    for (int k = 0; k < 20; k++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("sat.hit_count", int'(hc), 15);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk("sat.ready_with_clear", int'(bus.cpu_ready), 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    chk("sat.cleared", int'(hc), 0);

    // MEM_LATENCY=1: each memory state lasts one cycle.
    cyc1(1, 0, 0);
    chk_outs1("l1c.c0", 0,0,0,0,0,0);
    cyc1(1, 0, 0);
    chk_outs1("l1c.c1", 0,1,0,0,1,1);
    cyc1(1, 1, 0);
    chk_outs1("l1c.c2", 1,0,0,0,0,0);
    cyc1(0, 0, 0);
    cyc1(1, 0, 1);
    chk_outs1("l1d.c0", 0,0,0,0,0,0);
    cyc1(1, 0, 0);
    chk_outs1("l1d.c1", 0,0,1,1,0,1);
    cyc1(1, 0, 0);
    chk_outs1("l1d.c2", 0,1,0,0,1,1);
    cyc1(1, 1, 0);
    chk_outs1("l1d.c3", 1,0,0,0,0,0);
    cyc1(0, 0, 0);
    chk("l1.miss_count", int'(mc1), 2);
    chk("l1.wb_count", int'(wc1), 1);
    chk("l1.hit_count", int'(hc1), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
